hw_svm_multi: RTL and testbench

Streaming multi-class linear SVM inference engine, the parametrised successor to `hw_svm`. It accepts a feature vector as FEAT_N signed beats on a valid/ready stream and evaluates CLASS_N one-vs-rest linear scores in parallel. Each score is `bias[c] + Σ w[c][i]·x[i]`. It returns the argmax class, plus its score, on a valid/ready result stream. When CLASS_N = 1 it degenerates to the binary sign classifier. Weights and biases are runtime-loadable through a configuration port.

---
 rtl/hw_svm_multi_if.sv | 36 +++
 rtl/hw_svm_multi.sv | 119 +++++++++++
 tb/tb_hw_svm_multi.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hw_svm_multi_if.sv
// Stream and configuration bundle for the multi-class linear SVM engine.
// The master drives features, result backpressure and configuration writes;
// the slave (the engine) drives readiness and the registered result.
interface hw_svm_multi_if #(
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 16,
  parameter int FEAT_N   = 4,
  parameter int CLASS_N  = 4
);
  localparam int LABEL_W = (CLASS_N > 1) ? $clog2(CLASS_N) : 1;
  localparam int ACC_W   = DATA_W + WEIGHT_W + $clog2(FEAT_N + 1);
  localparam int IDX_W   = $clog2(FEAT_N + 1);

  logic signed [DATA_W-1:0]   test;
  logic                       test_valid;
  logic                       test_ready;
  logic [LABEL_W-1:0]         label;
  logic signed [ACC_W-1:0]    score;
  logic                       label_valid;
  logic                       label_ready;
  logic                       cfg_we;
  logic [LABEL_W-1:0]         cfg_class;
  logic [IDX_W-1:0]           cfg_idx;
  logic signed [WEIGHT_W-1:0] cfg_data;
  logic                       cfg_ready;

  modport master (
    output test, test_valid, label_ready, cfg_we, cfg_class, cfg_idx, cfg_data,
    input  test_ready, label, score, label_valid, cfg_ready
  );

  modport slave (
    input  test, test_valid, label_ready, cfg_we, cfg_class, cfg_idx, cfg_data,
    output test_ready, label, score, label_valid, cfg_ready
  );
endinterface

// File: rtl/hw_svm_multi.sv
// Streaming multi-class linear SVM: FEAT_N feature beats are multiplied into
// CLASS_N parallel accumulators (preloaded with the class bias), then a
// one-class-per-cycle argmax picks the winner (lowest index on ties). With a
// single class the label is the sign test score >= 0.
module hw_svm_multi #(
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 16,
  parameter int FEAT_N   = 4,
  parameter int CLASS_N  = 4
) (
  input  logic clk,
  input  logic rst,
  hw_svm_multi_if.slave bus
);
  localparam int LABEL_W = (CLASS_N > 1) ? $clog2(CLASS_N) : 1;
  localparam int ACC_W   = DATA_W + WEIGHT_W + $clog2(FEAT_N + 1);
  localparam int IDX_W   = $clog2(FEAT_N + 1);
  localparam int PROD_W  = DATA_W + WEIGHT_W;

  typedef enum logic [1:0] {ACCUM, ARGMAX, OUTPUT} state_t;

  state_t state, state_next;

  // Index FEAT_N of each row holds the class bias.
  logic signed [WEIGHT_W-1:0] wmem [CLASS_N][FEAT_N+1];
  logic signed [ACC_W-1:0]    acc_p0 [CLASS_N];
  logic signed [ACC_W-1:0]    best_score_p1;
  logic [LABEL_W-1:0]         best_label_p1;
  logic [IDX_W-1:0]           cnt;
  logic [LABEL_W-1:0]         sidx;
  logic                       beat, last_beat, scan_done, hshake, cfg_hit;

  // Full-precision product sign-extended into the accumulator width.
  function automatic logic signed [ACC_W-1:0] mac(
    input logic signed [ACC_W-1:0]    base,
    input logic signed [DATA_W-1:0]   x,
    input logic signed [WEIGHT_W-1:0] w
  );
    logic signed [PROD_W-1:0] prod;
    prod = x * w;
    return base + ACC_W'(prod);
  endfunction

  assign beat           = bus.test_valid && bus.test_ready;
  assign last_beat      = beat && (int'(cnt) == FEAT_N - 1);
  assign scan_done      = (state == ARGMAX) && (int'(sidx) == CLASS_N - 1);
  assign hshake         = bus.label_valid && bus.label_ready;
  assign bus.test_ready = (state == ACCUM);
  assign bus.cfg_ready  = (state == ACCUM) && (cnt == '0);
  assign cfg_hit        = bus.cfg_we && bus.cfg_ready &&
                          (int'(bus.cfg_class) < CLASS_N) && (int'(bus.cfg_idx) <= FEAT_N);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  // Next-state: accumulate a vector, scan classes, hold result until taken.
  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM:   if (last_beat) state_next = ARGMAX;
      ARGMAX:  if (scan_done) state_next = OUTPUT;
      OUTPUT:  if (hshake)    state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Weight/bias store; writes are only taken between vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CLASS_N; c++)
        for (int i = 0; i <= FEAT_N; i++) wmem[c][i] <= '0;
    end else if (cfg_hit) begin
      wmem[bus.cfg_class][bus.cfg_idx] <= bus.cfg_data;
    end
  end

  // Stage p0: feature counter and per-class multiply-accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int c = 0; c < CLASS_N; c++) acc_p0[c] <= '0;
    end else if (beat) begin
      cnt <= last_beat ? '0 : cnt + 1'b1;
      for (int c = 0; c < CLASS_N; c++)
        acc_p0[c] <= mac((cnt == '0) ? ACC_W'(wmem[c][FEAT_N]) : acc_p0[c],
                         bus.test, wmem[c][cnt]);
    end
  end

  // Stage p1: sequential argmax, then registered result with hold-until-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      sidx            <= '0;
      best_score_p1   <= '0;
      best_label_p1   <= '0;
      bus.label_valid <= 1'b0;
      bus.label       <= '0;
      bus.score       <= '0;
    end else begin
      if (state == ARGMAX) begin
        if (sidx == '0 || acc_p0[sidx] > best_score_p1) begin
          best_score_p1 <= acc_p0[sidx];
          best_label_p1 <= (CLASS_N == 1) ? LABEL_W'(~acc_p0[0][ACC_W-1]) : sidx;
        end
        sidx <= scan_done ? '0 : sidx + 1'b1;
      end
      if (state == OUTPUT && !bus.label_valid) begin
        bus.label       <= best_label_p1;
        bus.score       <= best_score_p1;
        bus.label_valid <= 1'b1;
      end else if (hshake) begin
        bus.label_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hw_svm_multi.sv
// Scoreboard bench for hw_svm_multi: a 4-class instance and a binary
// (single-class) instance, directed scenarios plus randomized vectors checked
// against a plain-arithmetic dot-product/argmax model.
module tb_hw_svm_multi;
  localparam int DATA_W   = 32;
  localparam int WEIGHT_W = 16;
  localparam int FEAT_N   = 4;
  localparam int CLASS_N  = 4;

  typedef struct {
    int     lbl;
    longint sc;
    int     rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t   q_main[$];
  exp_t   q_bin[$];
  longint wm[CLASS_N][FEAT_N+1];
  longint wb[FEAT_N+1];
  longint xv[FEAT_N];
  bit     lr_rand = 1'b0;
  logic   lr_force = 1'b1;
  int     hs_edge = 0;
  int     first_acc = 0;
  logic   mv_prev = 1'b0;
  logic   bv_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hw_svm_multi_if #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .FEAT_N(FEAT_N), .CLASS_N(CLASS_N)) m();
  hw_svm_multi_if #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .FEAT_N(FEAT_N), .CLASS_N(1)) bb();

  hw_svm_multi #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .FEAT_N(FEAT_N), .CLASS_N(CLASS_N)) dut (
    .clk(clk), .rst(rst), .bus(m)
  );
  hw_svm_multi #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .FEAT_N(FEAT_N), .CLASS_N(1)) dut_bin (
    .clk(clk), .rst(rst), .bus(bb)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: bias + dot product per class, strict-greater argmax.
  task automatic model(input bit sel, output int l, output longint s);
    longint sc[CLASS_N];
    if (sel) begin
      s = wb[FEAT_N];
      for (int i = 0; i < FEAT_N; i++) s += xv[i] * wb[i];
      l = (s >= 0) ? 1 : 0;
    end else begin
      for (int c = 0; c < CLASS_N; c++) begin
        sc[c] = wm[c][FEAT_N];
        for (int i = 0; i < FEAT_N; i++) sc[c] += xv[i] * wm[c][i];
      end
      l = 0;
      for (int c = 1; c < CLASS_N; c++) if (sc[c] > sc[l]) l = c;
      s = sc[l];
    end
  endtask

  task automatic push(input bit sel, input int l, input longint s);
    exp_t e;
    e.lbl = l;
    e.sc  = s;
    e.rise = cyc + (sel ? 2 : CLASS_N + 1);
    if (sel) q_bin.push_back(e);
    else     q_main.push_back(e);
  endtask

  task automatic clear_models();
    for (int c = 0; c < CLASS_N; c++)
      for (int i = 0; i <= FEAT_N; i++) wm[c][i] = 0;
    for (int i = 0; i <= FEAT_N; i++) wb[i] = 0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_models();
  endtask

  task automatic beat(input bit sel, input longint x);
    int n = 0;
    if (sel) begin bb.test = x[31:0]; bb.test_valid = 1'b1; end
    else     begin m.test  = x[31:0]; m.test_valid  = 1'b1; end
    while (((sel ? bb.test_ready : m.test_ready) == 1'b0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk("beat_wait_ready", 0, 1);
    @(posedge clk); #1;
    if (sel) bb.test_valid = 1'b0;
    else     m.test_valid  = 1'b0;
  endtask

  task automatic cfg(input bit sel, input int cls, input int idx, input logic signed [15:0] d);
    int n = 0;
    while (((sel ? bb.cfg_ready : m.cfg_ready) == 1'b0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk("cfg_wait_ready", 0, 1);
    if (sel) begin
      bb.cfg_class = 1'(cls); bb.cfg_idx = 3'(idx); bb.cfg_data = d; bb.cfg_we = 1'b1;
    end else begin
      m.cfg_class = 2'(cls); m.cfg_idx = 3'(idx); m.cfg_data = d; m.cfg_we = 1'b1;
    end
    @(posedge clk); #1;
    bb.cfg_we = 1'b0;
    m.cfg_we  = 1'b0;
    if (idx <= FEAT_N) begin
      if (sel && cls < 1) wb[idx] = longint'(d);
      if (!sel && cls < CLASS_N) wm[cls][idx] = longint'(d);
    end
  endtask

  // Send xv[] as one vector; expectation from the model or from given constants.
  task automatic vec(input bit sel, input bit use_model, input int l_req, input longint s_req);
    int l;
    longint s;
    if (use_model) model(sel, l, s);
    else begin l = l_req; s = s_req; end
    for (int i = 0; i < FEAT_N; i++) begin
      beat(sel, xv[i]);
      if (i == 0) first_acc = cyc;
    end
    push(sel, l, s);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_main.size() != 0 || q_bin.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", q_main.size() + q_bin.size(), 0);
  endtask

  // Result backpressure for the 4-class instance.
  initial begin
    m.label_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m.label_ready = lr_rand ? ($urandom_range(0, 2) != 0) : lr_force;
    end
  end

  // Monitor, 4-class instance: latency on rise, payload on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (m.label_valid && !mv_prev) begin
        chk("main_pending_on_valid", q_main.size(), 1);
        if (q_main.size() > 0) chk("main_latency", cyc, q_main[0].rise);
      end
      if (m.label_valid && m.label_ready && q_main.size() > 0) begin
        chk("main_label", m.label, q_main[0].lbl);
        chk("main_score", m.score, q_main[0].sc);
        void'(q_main.pop_front());
        hs_edge = cyc + 1;
      end
    end
    mv_prev <= m.label_valid;
  end

  // Monitor, binary instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (bb.label_valid && !bv_prev) begin
        chk("bin_pending_on_valid", q_bin.size(), 1);
        if (q_bin.size() > 0) chk("bin_latency", cyc, q_bin[0].rise);
      end
      if (bb.label_valid && bb.label_ready && q_bin.size() > 0) begin
        chk("bin_label", bb.label, q_bin[0].lbl);
        chk("bin_score", bb.score, q_bin[0].sc);
        void'(q_bin.pop_front());
      end
    end
    bv_prev <= bb.label_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wv;
    int r;
    m.test = '0; m.test_valid = 1'b0; m.cfg_we = 1'b0;
    m.cfg_class = '0; m.cfg_idx = '0; m.cfg_data = '0;
    bb.test = '0; bb.test_valid = 1'b0; bb.cfg_we = 1'b0;
    bb.cfg_class = '0; bb.cfg_idx = '0; bb.cfg_data = '0; bb.label_ready = 1'b1;
    clear_models();

    // Reset state and zero weights.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_test_ready", m.test_ready, 1);
    chk("rst_cfg_ready", m.cfg_ready, 1);
    chk("rst_label_valid", m.label_valid, 0);
    chk("rst_label", m.label, 0);
    chk("rst_score", m.score, 0);
    for (int i = 0; i < FEAT_N; i++) xv[i] = 'ha24e;
    vec(0, 0, 0, 0);
    chk("zero_valid_low_after_beats", m.label_valid, 0);
    wait_drain();

    // Identity weights.
    for (int c = 0; c < FEAT_N; c++) cfg(0, c, c, 16'sd1);
    xv[0] = 5; xv[1] = -3; xv[2] = 40000; xv[3] = 7;
    vec(0, 0, 2, 40000);
    wait_drain();

    // Tie-break on equal biases.
    pulse_rst();
    cfg(0, 0, FEAT_N, 16'sd3); cfg(0, 1, FEAT_N, 16'sd9);
    cfg(0, 2, FEAT_N, 16'sd9); cfg(0, 3, FEAT_N, 16'sd1);
    for (int i = 0; i < FEAT_N; i++) xv[i] = 0;
    vec(0, 0, 1, 9);
    wait_drain();

    // Extremes: most negative data times most negative weight.
    pulse_rst();
    for (int i = 0; i < FEAT_N; i++) cfg(0, 0, i, -16'sd32768);
    for (int i = 0; i < FEAT_N; i++) xv[i] = -64'sd2147483648;
    vec(0, 0, 0, 64'sd281474976710656);
    wait_drain();

    // Backpressure with a locked-out configuration write.
    lr_force = 1'b0;
    for (int i = 0; i < FEAT_N; i++) xv[i] = 1;
    vec(0, 0, 1, 0);
    n = 0;
    while (!m.label_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_valid_seen", m.label_valid, 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        m.cfg_class = 2'd1; m.cfg_idx = 3'd4; m.cfg_data = 16'sd500; m.cfg_we = 1'b1;
      end
      if (k == 4) m.cfg_we = 1'b0;
      chk("bp_label_hold", m.label, 1);
      chk("bp_score_hold", m.score, 0);
      chk("bp_valid_hold", m.label_valid, 1);
      chk("bp_test_ready_low", m.test_ready, 0);
      chk("bp_cfg_ready_low", m.cfg_ready, 0);
      @(posedge clk); #1;
    end
    lr_force = 1'b1;
    vec(0, 0, 1, 0);
    chk("bp_next_after_handshake", (first_acc > hs_edge) ? 1 : 0, 1);
    wait_drain();

    // Config write on the first beat: that beat sees the old bias.
    for (int i = 0; i < FEAT_N; i++) xv[i] = 0;
    m.cfg_class = 2'd2; m.cfg_idx = 3'd4; m.cfg_data = 16'sd77; m.cfg_we = 1'b1;
    beat(0, xv[0]);
    m.cfg_we = 1'b0;
    wm[2][FEAT_N] = 77;
    for (int i = 1; i < FEAT_N; i++) beat(0, xv[i]);
    push(0, 0, 0);
    vec(0, 0, 2, 77);
    wait_drain();

    // Reset mid-vector.
    beat(0, 123);
    beat(0, -77);
    pulse_rst();
    chk("midrst_test_ready", m.test_ready, 1);
    chk("midrst_cfg_ready", m.cfg_ready, 1);
    for (int i = 0; i < FEAT_N; i++) begin r = $urandom; xv[i] = longint'(r); end
    vec(0, 0, 0, 0);
    wait_drain();

    // Randomized vectors with random backpressure; late ones use tiny ranges for ties.
    lr_rand = 1'b1;
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 6; k++) begin
        wv = (it >= 14) ? int'($urandom_range(0, 4)) - 2 : int'($urandom);
        cfg(0, $urandom_range(0, 3), $urandom_range(0, 7), 16'(wv));
      end
      for (int i = 0; i < FEAT_N; i++) begin
        r = (it >= 14) ? int'($urandom_range(0, 1)) : int'($urandom);
        xv[i] = longint'(r);
      end
      vec(0, 1, 0, 0);
    end
    lr_rand = 1'b0;
    lr_force = 1'b1;
    wait_drain();

    // Binary instance: sign classifier.
    for (int i = 0; i < FEAT_N; i++) cfg(1, 0, i, 16'sd1);
    cfg(1, 0, FEAT_N, -16'sd10);
    cfg(1, 1, FEAT_N, 16'sd100);
    xv[0] = 2; xv[1] = 2; xv[2] = 2; xv[3] = 3;
    vec(1, 0, 0, -1);
    xv[3] = 4;
    vec(1, 0, 1, 0);
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i <= FEAT_N; i++) cfg(1, 0, i, 16'(int'($urandom_range(0, 40)) - 20));
      for (int i = 0; i < FEAT_N; i++) xv[i] = longint'(int'($urandom_range(0, 20)) - 10);
      vec(1, 1, 0, 0);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
